viol_reset_ctrl: RTL and testbench

VIOL_RESET_CTRL -- requirements
Module: viol_reset_ctrl

---
 rtl/casu_viol_pkg.sv | 25 ++
 rtl/viol_reset_ctrl.sv | 145 ++++++++++++++
 tb/tb_viol_reset_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/casu_viol_pkg.sv
// casu_viol_pkg
//   Shared definitions for the violation reset controller: FSM state
//   encoding, status register select codes and the bit positions of the
//   monitor reset requests within viol_req.
package casu_viol_pkg;

  // Code 2'd3 is unused and is treated as IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } viol_state_t;

  // rd_sel codes
  localparam logic [1:0] SEL_STATUS = 2'd0;  // {log_valid, 4'b0, log_cause, viol_cnt}
  localparam logic [1:0] SEL_PC     = 2'd1;  // log_pc
  localparam logic [1:0] SEL_ADDR   = 2'd2;  // log_addr
  localparam logic [1:0] SEL_STATE  = 2'd3;  // {13'b0, at_reset_handler, state}

  // viol_req bit indices
  localparam int VIOL_XSTACK = 0;
  localparam int VIOL_ATOMIC = 1;
  localparam int VIOL_DMA    = 2;

endpackage

// File: rtl/viol_reset_ctrl.sv
// viol_reset_ctrl
//   Turns level reset requests from the security monitors into a
//   stretched core reset and keeps a first-fault log of the violation.
//
//   Ports
//     clk        system clock, all state on posedge
//     rst_n      asynchronous active-low reset
//     viol_req   monitor reset requests (X_stack, atomicity, DMA)
//     pc         core program counter
//     data_addr  core data address
//     clr        clear-log strobe (honoured only while idle)
//     rd_sel     status register select
//     rd_data    status read data, combinational from rd_sel
//     sys_rst    registered, stretched core reset (active high)
//     log_valid  high while a first-fault record is held
module viol_reset_ctrl
  import casu_viol_pkg::*;
#(
  parameter int          HOLD_CYCLES   = 16,
  parameter int          DRAIN_MAX     = 256,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  viol_req,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        clr,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic        sys_rst,
  output logic        log_valid
);

  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] DRAIN_END = 16'(DRAIN_MAX - 1);

  viol_state_t state_reg;
  logic [7:0]  hold_cnt_reg;
  logic [15:0] drain_cnt_reg;
  logic        sys_rst_reg;
  logic        log_valid_reg;
  logic [2:0]  log_cause_reg;
  logic [15:0] log_pc_reg;
  logic [15:0] log_addr_reg;
  logic [7:0]  viol_cnt_reg;
  logic [15:0] pc_q;
  logic [15:0] addr_q;

  logic        viol_any;
  logic        log_held;   // record already held, seen after a same-cycle clr
  logic [7:0]  cnt_base;   // viol_cnt value the increment starts from
  logic [7:0]  cnt_inc;

  assign viol_any = |viol_req;
  assign log_held = log_valid_reg & ~clr;
  assign cnt_base = clr ? 8'd0 : viol_cnt_reg;
  assign cnt_inc  = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      sys_rst_reg   <= 1'b0;
      log_valid_reg <= 1'b0;
      log_cause_reg <= '0;
      log_pc_reg    <= '0;
      log_addr_reg  <= '0;
      viol_cnt_reg  <= '0;
      pc_q          <= '0;
      addr_q        <= '0;
    end else begin
      // Monitor requests arrive one cycle after the offending access, so
      // the log captures the delayed copies.
      pc_q   <= pc;
      addr_q <= data_addr;

      case (state_reg)
        ST_HOLD: begin
          // Runs to completion even if viol_req drops meanwhile.
          if (hold_cnt_reg == 8'd0) begin
            state_reg     <= ST_DRAIN;
            sys_rst_reg   <= 1'b0;
            drain_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 8'd1;
          end
        end

        ST_DRAIN: begin
          if (!viol_any) begin
            state_reg <= ST_IDLE;
          end else if (drain_cnt_reg == DRAIN_END) begin
            // Monitor never released: reset again, but this is the same
            // violation, so neither the count nor the log changes.
            state_reg    <= ST_HOLD;
            sys_rst_reg  <= 1'b1;
            hold_cnt_reg <= HOLD_LOAD;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 16'd1;
          end
        end

        default: begin  // ST_IDLE and the unused code
          state_reg <= ST_IDLE;
          if (viol_any) begin
            // A violation beats a same-cycle clr: the clr is folded into
            // log_held/cnt_base so the new record and a count of 1 result.
            state_reg    <= ST_HOLD;
            sys_rst_reg  <= 1'b1;
            hold_cnt_reg <= HOLD_LOAD;
            viol_cnt_reg <= cnt_inc;
            if (!log_held) begin
              log_valid_reg <= 1'b1;
              log_cause_reg <= viol_req;
              log_pc_reg    <= pc_q;
              log_addr_reg  <= addr_q;
            end
          end else if (clr) begin
            log_valid_reg <= 1'b0;
            log_cause_reg <= '0;
            log_pc_reg    <= '0;
            log_addr_reg  <= '0;
            viol_cnt_reg  <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_STATUS: rd_data = {log_valid_reg, 4'b0, log_cause_reg, viol_cnt_reg};
      SEL_PC:     rd_data = log_pc_reg;
      SEL_ADDR:   rd_data = log_addr_reg;
      default:    rd_data = {13'b0, (pc_q == RESET_HANDLER), state_reg};
    endcase
  end

  assign sys_rst   = sys_rst_reg;
  assign log_valid = log_valid_reg;

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// tb_viol_reset_ctrl
//   Directed bench for viol_reset_ctrl. A behavioural model tracks the
//   remaining reset-window length, drain age and log contents; a compare
//   process checks sys_rst, log_valid and rd_data against it on every
//   falling edge. Literal expectations pin the model on key scenarios.
module tb_viol_reset_ctrl;

  localparam int HOLD = 16;
  localparam int DMAX = 256;
  localparam logic [15:0] RVEC = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  viol_req = '0;
  logic [15:0] pc = '0;
  logic [15:0] data_addr = '0;
  logic        clr = 1'b0;
  logic [1:0]  rd_sel = '0;
  logic [15:0] rd_data;
  logic        sys_rst;
  logic        log_valid;

  int checks = 0;
  int errors = 0;

  viol_reset_ctrl #(.HOLD_CYCLES(HOLD), .DRAIN_MAX(DMAX), .RESET_HANDLER(RVEC)) dut (
    .clk(clk), .rst_n(rst_n), .viol_req(viol_req), .pc(pc),
    .data_addr(data_addr), .clr(clr), .rd_sel(rd_sel), .rd_data(rd_data),
    .sys_rst(sys_rst), .log_valid(log_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_left = 0;     // reset cycles still owed (sys_rst high while > 0)
  bit          m_drain = 0;    // waiting for the monitors to release
  int          m_age = 0;      // cycles spent waiting so far
  bit          m_valid = 0;
  logic [2:0]  m_cause = '0;
  logic [15:0] m_pc = '0, m_addr = '0;
  int          m_cnt = 0;
  logic [15:0] m_pcq = '0, m_addrq = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] prev_pc, prev_addr;
    if (!rst_n) begin
      m_left = 0; m_drain = 0; m_age = 0; m_valid = 0; m_cause = '0;
      m_pc = '0; m_addr = '0; m_cnt = 0; m_pcq = '0; m_addrq = '0;
    end else begin
      prev_pc = m_pcq; prev_addr = m_addrq;
      m_pcq = pc; m_addrq = data_addr;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_drain = 1; m_age = 0; end
      end else if (m_drain) begin
        if (viol_req == 0) m_drain = 0;
        else if (m_age == DMAX - 1) begin m_drain = 0; m_left = HOLD; end
        else m_age = m_age + 1;
      end else if (viol_req != 0) begin
        if (clr) begin m_valid = 0; m_cnt = 0; end
        if (!m_valid) begin
          m_valid = 1; m_cause = viol_req; m_pc = prev_pc; m_addr = prev_addr;
        end
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_left = HOLD;
      end else if (clr) begin
        m_valid = 0; m_cause = '0; m_pc = '0; m_addr = '0; m_cnt = 0;
      end
    end
  end

  function automatic logic [15:0] model_rd(input logic [1:0] sel);
    logic [1:0] st;
    st = (m_left > 0) ? 2'd1 : (m_drain ? 2'd2 : 2'd0);
    case (sel)
      2'd0:    return {m_valid, 4'b0, m_cause, 8'(m_cnt)};
      2'd1:    return m_pc;
      2'd2:    return m_addr;
      default: return {13'b0, (m_pcq == RVEC), st};
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] exp_rd;
    exp_rd = model_rd(rd_sel);
    checks++;
    if (sys_rst !== (m_left > 0) || log_valid !== m_valid || rd_data !== exp_rd) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t sel=%0d sys_rst=%b/%b log_valid=%b/%b rd_data=%h/%h (actual/required)",
               $time, rd_sel, sys_rst, (m_left > 0), log_valid, m_valid, rd_data, exp_rd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
    rd_sel = rd_sel + 2'd1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [15:0] val);
    rd_sel = sel; #1; val = rd_data;
  endtask

  task automatic wait_idle(input string name);
    logic [15:0] v;
    int n = 0;
    read_reg(2'd3, v);
    while (v[1:0] != 2'd0 && n < 700) begin
      tick(); read_reg(2'd3, v); n++;
    end
    checks++;
    if (v[1:0] != 2'd0) begin
      errors++;
      $display("FAIL %s idle_timeout actual_state=%0d required=0", name, v[1:0]);
    end
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (sys_rst == lvl && n < 1000) begin n++; tick(); end
  endtask

  initial begin
    logic [15:0] v;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 4; s++) begin
      read_reg(2'(s), v);
      chk($sformatf("reset_sel%0d", s), v, 16'h0000);
    end
    chk("reset_sys_rst", {15'b0, sys_rst}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // First violation: access at C010/A004, request one cycle later.
    pc = 16'hC010; data_addr = 16'hA004;
    tick();
    pc = 16'h1234; data_addr = 16'h5678; viol_req = 3'b001;
    tick();
    viol_req = 3'b000;
    count_level(1'b1, n);
    chk("hold_len_first", 16'(n), 16'd16);
    wait_idle("first");
    read_reg(2'd0, v); chk("first_sel0", v, 16'h8101);
    read_reg(2'd1, v); chk("first_sel1", v, 16'hC010);
    read_reg(2'd2, v); chk("first_sel2", v, 16'hA004);

    // Clear, then hold the request past the drain timeout.
    clr = 1'b1; tick(); clr = 1'b0;
    read_reg(2'd0, v); chk("clr_sel0", v, 16'h0000);
    viol_req = 3'b001; tick();
    count_level(1'b1, n);
    chk("hold_len_stuck", 16'(n), 16'd16);
    count_level(1'b0, n);
    chk("drain_timeout_len", 16'(n), 16'd256);
    chk("reentry_sys_rst", {15'b0, sys_rst}, 16'h0001);
    read_reg(2'd0, v); chk("reentry_sel0", v, 16'h8101);
    repeat (12) tick();
    viol_req = 3'b000;
    wait_idle("stuck");
    read_reg(2'd0, v); chk("after_stuck_sel0", v, 16'h8101);

    // Second violation keeps the first-fault record.
    viol_req = 3'b100; tick(); viol_req = 3'b000;
    wait_idle("second");
    read_reg(2'd0, v); chk("second_sel0", v, 16'h8102);

    // clr and violation in the same idle cycle.
    clr = 1'b1; viol_req = 3'b010; tick(); clr = 1'b0; viol_req = 3'b000;
    read_reg(2'd0, v); chk("clr_vs_viol_sel0", v, 16'h8201);
    wait_idle("clr_vs_viol");

    // Saturation of the violation counter.
    for (int i = 0; i < 300; i++) begin
      viol_req = 3'b001; tick(); viol_req = 3'b000;
      wait_idle("sat_loop");
    end
    read_reg(2'd0, v); chk("saturate_sel0", v, 16'h82FF);

    // Reset in the middle of HOLD.
    viol_req = 3'b001; tick(); viol_req = 3'b000;
    repeat (4) tick();
    chk("mid_hold_sys_rst", {15'b0, sys_rst}, 16'h0001);
    rst_n = 1'b0; #1;
    chk("abort_sys_rst", {15'b0, sys_rst}, 16'h0000);
    read_reg(2'd3, v); chk("abort_sel3", v, 16'h0000);
    read_reg(2'd0, v); chk("abort_sel0", v, 16'h0000);
    tick(); tick();
    rst_n = 1'b1; viol_req = 3'b001;
    tick();
    viol_req = 3'b000;
    chk("post_reset_sys_rst", {15'b0, sys_rst}, 16'h0001);
    read_reg(2'd0, v); chk("post_reset_sel0", v, 16'h8101);
    wait_idle("post_reset");

    // Reset-handler indication.
    pc = RVEC; tick();
    read_reg(2'd3, v); chk("at_handler_sel3", v, 16'h0004);
    pc = 16'h0100; tick();
    read_reg(2'd3, v); chk("off_handler_sel3", v, 16'h0000);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
